// File: rtl/enemy_pkg.sv
// Shared constants and helpers for the enemy sprite blocks: screen geometry, colours, LFSR taps.
package enemy_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned SPRITE_DIM = 4;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_BLUE  = 3'b001;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;
  localparam logic [2:0] COLOUR_RED   = 3'b100;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  // Galois mask for x^8+x^6+x^5+x^4+1 in right-shift form.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// Free-running 8-bit Galois LFSR; steps every clock, reloads seed on resetn only.
module enemy_lfsr
  import enemy_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_d;

  always_comb begin
    value_d = lfsr_next(value);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      value <= seed;
    end else begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/enemy_sprite_datapath.sv
// Enemy sprite datapath: position, colour, pixel/delay counters and registered 4x4 pixel pipe.
// Optional bullet hit detection is built when ENEMY_HIT_EN is defined.
module enemy_sprite_datapath
  import enemy_pkg::*;
#(
  parameter logic [6:0]  Y_TOP     = 7'd0,
  parameter logic [6:0]  Y_BOTTOM  = 7'd110,
  parameter logic [6:0]  Y_STEP    = 7'd1,
  parameter logic [7:0]  X_MIN     = 8'd16,
  parameter logic [7:0]  X_INIT    = 8'd40,
  parameter logic [2:0]  COLOUR    = COLOUR_RED,
  parameter int unsigned DIV_W     = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       en_reset,
  input  logic       loadX,
  input  logic       loadY,
  input  logic       load_colour,
  input  logic       load_black,
  input  logic       plot,
  input  logic       en_counter,
  input  logic       en_delay_counter,
  input  logic       reset_delay,
`ifdef ENEMY_HIT_EN
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  output logic       hit,
`endif
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [3:0] cnt,
  output logic [3:0] delay_cnt,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot_out
);

  logic [7:0]       lfsr_value;
  logic [2:0]       colour_reg;
  logic [DIV_W-1:0] prescaler;
  logic [7:0]       pix_x;
  logic [6:0]       pix_y;
  logic             init;

  enemy_lfsr u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .seed   (LFSR_SEED),
    .value  (lfsr_value)
  );

  always_comb begin
    init  = !resetn || en_reset;
    pix_x = X + {6'd0, cnt[1:0]};
    pix_y = Y + {5'd0, cnt[3:2]};
  end

  always_ff @(posedge clock) begin
    if (init) begin
      X          <= X_INIT;
      Y          <= Y_TOP;
      cnt        <= 4'd0;
      delay_cnt  <= 4'd0;
      prescaler  <= '0;
      colour_reg <= COLOUR_BLACK;
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour_out <= COLOUR_BLACK;
      plot_out   <= 1'b0;
    end else begin
      if (loadX) begin
        X <= X_MIN + {1'b0, lfsr_value[6:0]};
      end
      if (loadY) begin
        Y <= (Y >= Y_BOTTOM) ? Y_TOP : Y + Y_STEP;
      end
      if (en_counter) begin
        cnt <= cnt + 4'd1;
      end
      if (load_colour) begin
        colour_reg <= COLOUR;
      end

      // A new row restarts the frame hold regardless of the delay strobes.
      if (loadY) begin
        delay_cnt <= 4'd0;
        prescaler <= '0;
      end else if (en_delay_counter) begin
        prescaler <= prescaler + DIV_W'(1);
        if ((&prescaler) && (delay_cnt != 4'hF)) begin
          delay_cnt <= delay_cnt + 4'd1;
        end
      end else if (reset_delay) begin
        delay_cnt <= 4'd0;
        prescaler <= '0;
      end

      x_out      <= pix_x;
      y_out      <= pix_y;
      colour_out <= load_black ? COLOUR_BLACK : colour_reg;
      plot_out   <= plot;
    end
  end

`ifdef ENEMY_HIT_EN
  always_ff @(posedge clock) begin
    if (init || loadX) begin
      hit <= 1'b0;
    end else if (plot && !load_black && (pix_x == bullet_x) && (pix_y == bullet_y)) begin
      hit <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_enemy_sprite_datapath.sv
// Directed, table-driven bench for enemy_sprite_datapath (hit checks when ENEMY_HIT_EN is defined).
module tb_enemy_sprite_datapath;

  logic       clock = 1'b0;
  logic       resetn, en_reset, loadX, loadY, load_colour, load_black, plot;
  logic       en_counter, en_delay_counter, reset_delay;
  logic [7:0] X, x_out;
  logic [6:0] Y, y_out;
  logic [3:0] cnt, delay_cnt;
  logic [2:0] colour_out;
  logic       plot_out;
`ifdef ENEMY_HIT_EN
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic       hit;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] lfsr_m;
  logic [7:0] exp_x;

  always #5 clock = ~clock;

  enemy_sprite_datapath dut (
    .clock            (clock),
    .resetn           (resetn),
    .en_reset         (en_reset),
    .loadX            (loadX),
    .loadY            (loadY),
    .load_colour      (load_colour),
    .load_black       (load_black),
    .plot             (plot),
    .en_counter       (en_counter),
    .en_delay_counter (en_delay_counter),
    .reset_delay      (reset_delay),
`ifdef ENEMY_HIT_EN
    .bullet_x         (bullet_x),
    .bullet_y         (bullet_y),
    .hit              (hit),
`endif
    .X                (X),
    .Y                (Y),
    .cnt              (cnt),
    .delay_cnt        (delay_cnt),
    .x_out            (x_out),
    .y_out            (y_out),
    .colour_out       (colour_out),
    .plot_out         (plot_out)
  );

  // Reference LFSR: x^8+x^6+x^5+x^4+1, Galois right-shift, seed 8'hA5.
  always @(posedge clock) begin
    if (!resetn) lfsr_m <= 8'hA5;
    else         lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 8'hB8) : (lfsr_m >> 1);
  end

  typedef struct {
    logic       en_reset, load_y, load_colour, load_black, plot, en_counter;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [3:0] ecnt;
    logic [7:0] exo;
    logic [6:0] eyo;
    logic [2:0] ecol;
    logic       eplot;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle();
    en_reset = 0; loadX = 0; loadY = 0; load_colour = 0; load_black = 0; plot = 0;
    en_counter = 0; en_delay_counter = 0; reset_delay = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_X"}, 32'(X), 32'd40);
    check({tag, "_Y"}, 32'(Y), 32'd0);
    check({tag, "_cnt"}, 32'(cnt), 32'd0);
    check({tag, "_delay"}, 32'(delay_cnt), 32'd0);
    check({tag, "_x_out"}, 32'(x_out), 32'd0);
    check({tag, "_y_out"}, 32'(y_out), 32'd0);
    check({tag, "_colour"}, 32'(colour_out), 32'd0);
    check({tag, "_plot"}, 32'(plot_out), 32'd0);
  endtask

  initial begin
    //          rst   ldY   ldC   blk   plot  cnt   X      Y     cnt   xo     yo    col     plot
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd40, 7'd0, 4'd0, 8'd40, 7'd0, 3'b000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd40, 7'd0, 4'd0, 8'd40, 7'd0, 3'b000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 7'd1, 4'd0, 8'd40, 7'd0, 3'b100, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd40, 7'd1, 4'd1, 8'd40, 7'd1, 3'b100, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd40, 7'd2, 4'd2, 8'd41, 7'd1, 3'b100, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd40, 7'd2, 4'd2, 8'd42, 7'd2, 3'b000, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd40, 7'd0, 4'd0, 8'd0,  7'd0, 3'b000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 7'd0, 4'd0, 8'd40, 7'd0, 3'b000, 1'b1};

    idle();
`ifdef ENEMY_HIT_EN
    bullet_x = 8'd200;
    bullet_y = 7'd100;
`endif
    resetn = 0;
    tick();
    tick();
    check_reset_state("reset");
    resetn = 1;

    // Table: strobe combinations and their registered effects.
    for (int i = 0; i < 8; i++) begin
      idle();
      en_reset = vecs[i].en_reset;  loadY = vecs[i].load_y;
      load_colour = vecs[i].load_colour; load_black = vecs[i].load_black;
      plot = vecs[i].plot; en_counter = vecs[i].en_counter;
      tick();
      check($sformatf("vec%0d_X", i), 32'(X), 32'(vecs[i].ex));
      check($sformatf("vec%0d_Y", i), 32'(Y), 32'(vecs[i].ey));
      check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].ecnt));
      check($sformatf("vec%0d_x_out", i), 32'(x_out), 32'(vecs[i].exo));
      check($sformatf("vec%0d_y_out", i), 32'(y_out), 32'(vecs[i].eyo));
      check($sformatf("vec%0d_colour", i), 32'(colour_out), 32'(vecs[i].ecol));
      check($sformatf("vec%0d_plot", i), 32'(plot_out), 32'(vecs[i].eplot));
    end

    // Draw pass: sweep 40..43 x 1..4 in red.
    idle(); en_reset = 1; tick();
    idle(); load_colour = 1; loadY = 1; tick();
    for (int k = 0; k < 16; k++) begin
      idle(); plot = 1; en_counter = 1; tick();
      check($sformatf("draw%0d_x", k), 32'(x_out), 32'(40 + (k % 4)));
      check($sformatf("draw%0d_y", k), 32'(y_out), 32'(1 + (k / 4)));
      check($sformatf("draw%0d_col", k), 32'(colour_out), 32'd4);
      check($sformatf("draw%0d_plot", k), 32'(plot_out), 32'd1);
    end
    check("draw_cnt_wrap", 32'(cnt), 32'd0);

    // Delay prescaler: one delay tick per 16 enabled cycles, saturating at 15.
    idle(); reset_delay = 1; tick();
    for (int n = 1; n <= 272; n++) begin
      idle(); en_delay_counter = 1; tick();
      if (n == 15)  check("delay_n15", 32'(delay_cnt), 32'd0);
      if (n == 16)  check("delay_n16", 32'(delay_cnt), 32'd1);
      if (n == 239) check("delay_n239", 32'(delay_cnt), 32'd14);
      if (n == 240) check("delay_n240", 32'(delay_cnt), 32'd15);
      if (n == 272) check("delay_sat", 32'(delay_cnt), 32'd15);
    end
    idle(); reset_delay = 1; tick();
    check("delay_cleared", 32'(delay_cnt), 32'd0);
    for (int n = 0; n < 16; n++) begin
      idle(); en_delay_counter = 1; reset_delay = 1; tick();
    end
    check("delay_en_priority", 32'(delay_cnt), 32'd1);
    idle(); loadY = 1; en_delay_counter = 1; tick();
    check("delay_loady_clear", 32'(delay_cnt), 32'd0);

    // Respawn: walk Y to the bottom, then loadX+loadY together.
    idle(); en_reset = 1; tick();
    for (int n = 0; n < 110; n++) begin
      idle(); loadY = 1; tick();
    end
    check("y_bottom", 32'(Y), 32'd110);
    idle(); loadX = 1; loadY = 1;
    exp_x = 8'd16 + {1'b0, lfsr_m[6:0]};
    tick();
    check("respawn_y", 32'(Y), 32'd0);
    check("respawn_x", 32'(X), 32'(exp_x));
    check("respawn_x_range", 32'((X >= 8'd16) && (X <= 8'd143)), 32'd1);
    idle(); loadY = 1; tick();
    check("y_after_wrap", 32'(Y), 32'd1);

    // Erase pass, interrupted by en_reset.
    idle(); en_reset = 1; tick();
    idle(); load_colour = 1; tick();
    for (int k = 0; k < 8; k++) begin
      idle(); load_black = 1; plot = 1; en_counter = 1; tick();
      check($sformatf("erase%0d_col", k), 32'(colour_out), 32'd0);
      check($sformatf("erase%0d_plot", k), 32'(plot_out), 32'd1);
      check($sformatf("erase%0d_x", k), 32'(x_out), 32'(40 + (k % 4)));
    end
    idle(); en_reset = 1; load_black = 1; plot = 1; en_counter = 1; loadY = 1; tick();
    check_reset_state("erase_reset");

`ifdef ENEMY_HIT_EN
    idle(); en_reset = 1; tick();
    check("hit_reset", 32'(hit), 32'd0);
    idle(); load_colour = 1; loadY = 1; tick();
    idle(); loadY = 1; tick();
    check("hit_setup_y", 32'(Y), 32'd2);
    bullet_x = 8'd42;
    bullet_y = 7'd3;
    for (int k = 0; k < 16; k++) begin
      idle(); plot = 1; en_counter = 1; tick();
      check($sformatf("hit_after_px%0d", k), 32'(hit), 32'(k >= 6));
    end
    idle(); tick(); tick();
    check("hit_sticky", 32'(hit), 32'd1);
    idle(); loadX = 1; tick();
    check("hit_clear_loadx", 32'(hit), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
